// File: rtl/ram_if.sv
// rtl/ram_if.sv - bus bundle between a RAM requester and the ram block
interface ram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  write_enable;
  logic                  ram_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output write_enable,
    output ram_read,
    output address,
    output write_data,
    input  data_out
  );

  modport slave (
    input  write_enable,
    input  ram_read,
    input  address,
    input  write_data,
    output data_out
  );
endinterface

// File: rtl/ram.sv
// rtl/ram.sv - single-port RAM, synchronous write, combinational gated read
module ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  ram_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;

  // Reset clears every word in one edge and wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.write_enable) begin
      mem_q[bus.address] <= bus.write_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.ram_read) begin
      rd_data = mem_q[bus.address];
    end
  end

  assign bus.data_out = rd_data;
endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - directed stimulus with a queue-based scoreboard for ram
module tb_ram;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clk;
  logic reset;

  ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] exp_q [$];
  string         name_q [$];
  int            checks;
  int            errors;
  event          sample_ev;

  // Monitor: whenever stimulus announces a settled output, pop and compare.
  initial begin
    checks = 0;
    errors = 0;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        string         n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (bus.data_out !== e) begin
          errors++;
          $display("FAIL %s: data_out=0x%04h expected=0x%04h", n, bus.data_out, e);
        end
      end
    end
  end

  task automatic expect_out(input string n, input logic [DW-1:0] e);
    #1;
    exp_q.push_back(e);
    name_q.push_back(n);
    ->sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic we, input logic rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    bus.write_enable = we;
    bus.ram_read     = rd;
    bus.address      = a;
    bus.write_data   = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_bus(1'b0, 1'b0, 8'h00, 16'h0000);
    tick();
    reset = 1'b0;

    // Reset state
    expect_out("rst_rd0", 16'h0000);
    bus.ram_read = 1'b1;
    expect_out("rst_a00", 16'h0000);
    bus.address = 8'hFF;
    expect_out("rst_aFF", 16'h0000);

    // Write then immediate combinational read, address change without clock
    set_bus(1'b1, 1'b1, 8'h00, 16'h4002);
    tick();
    bus.write_enable = 1'b0;
    expect_out("wr_a00", 16'h4002);
    bus.address = 8'h01;
    expect_out("a01_clean", 16'h0000);

    // Output enable gating
    set_bus(1'b1, 1'b1, 8'h01, 16'hBEEF);
    tick();
    bus.write_enable = 1'b0;
    bus.ram_read = 1'b0;
    expect_out("gate_off", 16'h0000);
    bus.ram_read = 1'b1;
    expect_out("gate_on", 16'hBEEF);

    // Read-during-write on a held address
    set_bus(1'b1, 1'b1, 8'h05, 16'h1234);
    expect_out("rdw_pre", 16'h0000);
    tick();
    bus.write_data = 16'hABCD;
    expect_out("rdw_mid", 16'h1234);
    tick();
    bus.write_enable = 1'b0;
    expect_out("rdw_post", 16'hABCD);

    // Top-address boundary and neighbour isolation
    set_bus(1'b1, 1'b1, 8'hFF, 16'h7FFF);
    tick();
    bus.write_enable = 1'b0;
    expect_out("a_FF", 16'h7FFF);
    bus.address = 8'hFE;
    expect_out("a_FE", 16'h0000);
    bus.address = 8'h00;
    expect_out("a00_kept", 16'h4002);

    // Reset raised mid-operation: reads see old contents until the edge
    reset = 1'b1;
    set_bus(1'b0, 1'b1, 8'h01, 16'h0000);
    expect_out("rst_pre_edge", 16'hBEEF);
    set_bus(1'b1, 1'b1, 8'h02, 16'hFFFF);
    tick();
    reset = 1'b0;
    bus.write_enable = 1'b0;
    expect_out("rst_wr_a02", 16'h0000);
    bus.address = 8'h00;
    expect_out("rst_a00", 16'h0000);
    bus.address = 8'h01;
    expect_out("rst_a01", 16'h0000);
    bus.address = 8'h05;
    expect_out("rst_a05", 16'h0000);
    bus.address = 8'hFF;
    expect_out("rst_aFF2", 16'h0000);

    // Write while output disabled
    set_bus(1'b1, 1'b0, 8'h10, 16'h4002);
    tick();
    bus.write_enable = 1'b0;
    expect_out("wr_hidden", 16'h0000);
    bus.ram_read = 1'b1;
    expect_out("wr_shown", 16'h4002);
    bus.address = 8'h11;
    expect_out("a11_clean", 16'h0000);

    // Write-enable low leaves contents unchanged
    set_bus(1'b0, 1'b1, 8'h10, 16'h5555);
    tick();
    expect_out("we_low", 16'h4002);

    #5;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending: %0d expected values never compared, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
